// File: rtl/conv_add_tree_acc_if.sv
// rtl/conv_add_tree_acc_if.sv - beat input and result output bundle for conv_add_tree_acc
interface conv_add_tree_acc_if #(
    parameter int N_IN   = 11,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) ();
    logic                   en;
    logic                   clr;
    logic                   in_valid;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [DATA_W-1:0]      in_bias;
    logic                   out_valid;
    logic [ACC_W-1:0]       out_data;
    logic                   out_ovf;

    modport master (
        output en, clr, in_valid, in_data, in_bias,
        input  out_valid, out_data, out_ovf
    );

    modport slave (
        input  en, clr, in_valid, in_data, in_bias,
        output out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/conv_add_tree_acc.sv
// rtl/conv_add_tree_acc.sv - pipelined signed adder tree with bias and channel accumulation
// Optional saturation of stage 2/3 adders: define CONV_ADD_TREE_SAT_EN.
module conv_add_tree_acc #(
    parameter int N_IN     = 11,
    parameter int DATA_W   = 32,
    parameter int GROUP    = 6,
    parameter int ACC_W    = 32,
    parameter int CHANNELS = 1
) (
    input  logic               clk,
    input  logic               rst_b,
    conv_add_tree_acc_if.slave bus
);
    localparam int G     = (N_IN + GROUP) / GROUP;
    localparam int SLOTS = G * GROUP;
    localparam int S2_W  = ACC_W + $clog2(G) + 1;
    localparam int S3_W  = ACC_W + 1;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

`ifdef CONV_ADD_TREE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic acc_t fit(input logic ovf, input logic neg, input acc_t wrapped);
        if (SAT && ovf)
            return neg ? ACC_MIN : ACC_MAX;
        return wrapped;
    endfunction

    logic [CW-1:0] in_cnt;
    logic [CW-1:0] ch_cnt;
    acc_t          elem [SLOTS];
    acc_t          grp_sum [G];
    acc_t          s1 [G];
    logic          v1;
    acc_t          s2;
    logic          v2;
    logic          ovf2;
    acc_t          acc;
    logic          ovf_sticky;
    logic          out_pend;
    acc_t          out_data_r;
    logic          out_ovf_r;

    // Bias rides in the slot right after the last product, only on channel beat 0.
    always_comb begin
        for (int i = 0; i < SLOTS; i++)
            elem[i] = '0;
        for (int i = 0; i < N_IN; i++)
            elem[i] = acc_t'(signed'(bus.in_data[(N_IN-i)*DATA_W-1 -: DATA_W]));
        if (in_cnt == '0)
            elem[N_IN] = acc_t'(signed'(bus.in_bias));
    end

    always_comb begin
        for (int g = 0; g < G; g++) begin
            grp_sum[g] = '0;
            for (int k = 0; k < GROUP; k++)
                grp_sum[g] = grp_sum[g] + elem[g*GROUP + k];
        end
    end

    logic signed [S2_W-1:0] sum2_w;
    logic                   ovf2_c;
    acc_t                   s2_next;

    always_comb begin
        sum2_w = '0;
        for (int g = 0; g < G; g++)
            sum2_w = sum2_w + S2_W'(s1[g]);
    end

    assign ovf2_c  = !((&sum2_w[S2_W-1:ACC_W-1]) || !(|sum2_w[S2_W-1:ACC_W-1]));
    assign s2_next = fit(ovf2_c, sum2_w[S2_W-1], sum2_w[ACC_W-1:0]);

    logic signed [S3_W-1:0] sum3_w;
    logic                   ovf3_c;
    logic                   first_ch;
    logic                   last_ch;
    acc_t                   acc_next;
    logic                   ovf_next;

    assign sum3_w   = S3_W'(acc) + S3_W'(s2);
    assign ovf3_c   = sum3_w[S3_W-1] ^ sum3_w[ACC_W-1];
    assign first_ch = (ch_cnt == '0);
    assign last_ch  = (ch_cnt == LAST_CH);
    assign acc_next = first_ch ? s2 : fit(ovf3_c, sum3_w[S3_W-1], sum3_w[ACC_W-1:0]);
    assign ovf_next = first_ch ? ovf2 : (ovf_sticky | ovf2 | ovf3_c);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int g = 0; g < G; g++)
                s1[g] <= '0;
            v1         <= 1'b0;
            s2         <= '0;
            v2         <= 1'b0;
            ovf2       <= 1'b0;
            in_cnt     <= '0;
            ch_cnt     <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            out_pend   <= 1'b0;
            out_data_r <= '0;
            out_ovf_r  <= 1'b0;
        end else if (bus.en) begin
            if (bus.clr) begin
                v1         <= 1'b0;
                v2         <= 1'b0;
                in_cnt     <= '0;
                ch_cnt     <= '0;
                ovf_sticky <= 1'b0;
                out_pend   <= 1'b0;
            end else begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    s1     <= grp_sum;
                    in_cnt <= (in_cnt == LAST_CH) ? '0 : in_cnt + CW'(1);
                end
                v2 <= v1;
                if (v1) begin
                    s2   <= s2_next;
                    ovf2 <= ovf2_c;
                end
                out_pend <= v2 && last_ch;
                if (v2) begin
                    acc        <= acc_next;
                    ovf_sticky <= ovf_next;
                    ch_cnt     <= last_ch ? '0 : ch_cnt + CW'(1);
                    if (last_ch) begin
                        out_data_r <= acc_next;
                        out_ovf_r  <= ovf_next;
                    end
                end
            end
        end
    end

    // A finished result waits in out_pend through a stall and is shown once en returns.
    assign bus.out_valid = out_pend & bus.en;
    assign bus.out_data  = out_data_r;
    assign bus.out_ovf   = out_ovf_r;
endmodule

// File: tb/tb_conv_add_tree_acc.sv
// tb/tb_conv_add_tree_acc.sv - self-checking bench for conv_add_tree_acc (CHANNELS 1, 2, 3)
module tb_conv_add_tree_acc;
    localparam int N_IN   = 11;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 32;
    localparam int GROUP  = 6;
    localparam int G      = (N_IN + GROUP) / GROUP;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    logic en, clr, in_valid;
    int   prod [N_IN];
    int   bias;
    logic [N_IN*DATA_W-1:0] in_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N_IN; i++)
            in_data[(N_IN-i)*DATA_W-1 -: DATA_W] = prod[i];
    end

    conv_add_tree_acc_if #(.N_IN(N_IN), .DATA_W(DATA_W), .ACC_W(ACC_W)) i1 ();
    conv_add_tree_acc_if #(.N_IN(N_IN), .DATA_W(DATA_W), .ACC_W(ACC_W)) i2 ();
    conv_add_tree_acc_if #(.N_IN(N_IN), .DATA_W(DATA_W), .ACC_W(ACC_W)) i3 ();

    assign {i1.en, i1.clr, i1.in_valid, i1.in_data, i1.in_bias} = {en, clr, in_valid, in_data, bias};
    assign {i2.en, i2.clr, i2.in_valid, i2.in_data, i2.in_bias} = {en, clr, in_valid, in_data, bias};
    assign {i3.en, i3.clr, i3.in_valid, i3.in_data, i3.in_bias} = {en, clr, in_valid, in_data, bias};

    conv_add_tree_acc #(.N_IN(N_IN), .DATA_W(DATA_W), .GROUP(GROUP), .ACC_W(ACC_W), .CHANNELS(1))
        dut1 (.clk(clk), .rst_b(rst_b), .bus(i1));
    conv_add_tree_acc #(.N_IN(N_IN), .DATA_W(DATA_W), .GROUP(GROUP), .ACC_W(ACC_W), .CHANNELS(2))
        dut2 (.clk(clk), .rst_b(rst_b), .bus(i2));
    conv_add_tree_acc #(.N_IN(N_IN), .DATA_W(DATA_W), .GROUP(GROUP), .ACC_W(ACC_W), .CHANNELS(3))
        dut3 (.clk(clk), .rst_b(rst_b), .bus(i3));

    logic        ov [3];
    logic [31:0] od [3];
    logic        oo [3];
    assign ov[0] = i1.out_valid; assign od[0] = i1.out_data; assign oo[0] = i1.out_ovf;
    assign ov[1] = i2.out_valid; assign od[1] = i2.out_data; assign oo[1] = i2.out_ovf;
    assign ov[2] = i3.out_valid; assign od[2] = i3.out_data; assign oo[2] = i3.out_ovf;

    // Reference model: index c models CHANNELS = c+1, one beat at a time in plain integer math.
    typedef struct {
        int d;
        bit o;
    } exp_t;

    int   m_k [3];
    int   m_acc [3];
    bit   m_ovf [3];
    exp_t expq [3][$];
    int   out_cnt [3];
    int   last_d [3];
    bit   last_o [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int fit(input longint x, output bit o);
        o = (x > 64'sd2147483647) || (x < -64'sd2147483648);
`ifdef CONV_ADD_TREE_SAT_EN
        if (x > 64'sd2147483647) return 32'h7fffffff;
        if (x < -64'sd2147483648) return int'(32'h80000000);
`endif
        return int'(x);
    endfunction

    function automatic void model_beat(input int c);
        longint s2x;
        int     gs, s2;
        bit     o2, o3;
        exp_t   e;
        s2x = 0;
        for (int g = 0; g < G; g++) begin
            gs = 0;
            for (int j = g*GROUP; j < (g+1)*GROUP; j++) begin
                if (j < N_IN) gs += prod[j];
                else if (j == N_IN && m_k[c] == 0) gs += bias;
            end
            s2x += longint'(gs);
        end
        s2 = fit(s2x, o2);
        if (m_k[c] == 0) begin
            m_acc[c] = s2;
            m_ovf[c] = o2;
        end else begin
            m_acc[c] = fit(longint'(m_acc[c]) + longint'(s2), o3);
            m_ovf[c] = m_ovf[c] | o2 | o3;
        end
        if (m_k[c] == c) begin
            e.d = m_acc[c];
            e.o = m_ovf[c];
            expq[c].push_back(e);
            m_k[c] = 0;
        end else begin
            m_k[c]++;
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_k[c] = 0;
            m_acc[c] = 0;
            m_ovf[c] = 0;
            expq[c].delete();
        end
    endfunction

    task automatic tick();
        if (en && clr) begin
            for (int c = 0; c < 3; c++) begin
                m_k[c] = 0;
                m_ovf[c] = 0;
            end
        end else if (en && in_valid) begin
            for (int c = 0; c < 3; c++) model_beat(c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resync();
        in_valid = 1'b0;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic set_all(input int v, input int b);
        for (int i = 0; i < N_IN; i++) prod[i] = v;
        bias = b;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                if (ov[c] === 1'b1) begin
                    out_cnt[c]++;
                    last_d[c] = od[c];
                    last_o[c] = oo[c];
                    if (expq[c].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mon%0d unexpected out_valid, data 0x%08h expected none", c+1, od[c]);
                    end else begin
                        e = expq[c].pop_front();
                        chk($sformatf("mon%0d data", c+1), od[c], e.d);
                        chk($sformatf("mon%0d ovf", c+1), {31'b0, oo[c]}, {31'b0, e.o});
                    end
                end
            end
        end
    end

    typedef struct {
        int base;
        int step;
        int b;
        int exp_d;
        bit exp_o;
    } vec_t;

    initial begin
        vec_t vt [5];
        int   cnt;
        vt[0] = '{1, 1, 100, 166, 1'b0};
        vt[1] = '{0, 0, 0, 0, 1'b0};
        vt[2] = '{-5, 0, 7, -48, 1'b0};
        vt[3] = '{10, -3, -1, -56, 1'b0};
        vt[4] = '{1000, 1000, 0, 66000, 1'b0};

        en = 1'b1; clr = 1'b0; in_valid = 1'b0;
        set_all(0, 0);
        for (int c = 0; c < 3; c++) begin
            out_cnt[c] = 0;
            last_d[c] = 0;
            last_o[c] = 0;
        end
        model_reset();

        #1 rst_b = 1'b0;
        #1;
        chk("reset out_valid", {31'b0, i1.out_valid}, 0);
        chk("reset out_data", i1.out_data, 0);
        chk("reset out_ovf", {31'b0, i1.out_ovf}, 0);
        chk("reset out_data ch3", i3.out_data, 0);
        @(posedge clk);
        #1 rst_b = 1'b1;
        tick();

        // single-beat table on CHANNELS=1, latency checked on the first entry
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N_IN; i++) prod[i] = vt[v].base + vt[v].step * i;
            bias = vt[v].b;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            if (v == 0) chk("latency early", {31'b0, i1.out_valid}, 0);
            tick();
            chk($sformatf("vec%0d valid", v), {31'b0, i1.out_valid}, 1);
            chk($sformatf("vec%0d data", v), i1.out_data, vt[v].exp_d);
            chk($sformatf("vec%0d ovf", v), {31'b0, i1.out_ovf}, {31'b0, vt[v].exp_o});
            if (v == 0) begin
                tick();
                chk("single pulse", {31'b0, i1.out_valid}, 0);
            end
        end

        // CHANNELS=3: bias counted once over three beats
        resync();
        cnt = out_cnt[2];
        set_all(2, 5);
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("ch3 count", out_cnt[2] - cnt, 1);
        chk("ch3 sum", last_d[2], 71);

        // back-to-back with a two-cycle stall
        resync();
        cnt = out_cnt[0];
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N_IN; i++) prod[i] = int'($urandom_range(0, 200)) - 100;
            bias = int'($urandom_range(0, 50));
            in_valid = 1'b1;
            tick();
            if (b == 2) begin
                en = 1'b0;
                repeat (2) begin
                    #1 chk("stall no valid", {31'b0, i1.out_valid}, 0);
                    tick();
                end
                en = 1'b1;
            end
        end
        in_valid = 1'b0;
        repeat (5) tick();
        chk("stream count", out_cnt[0] - cnt, 4);

        // CHANNELS=2: clr discards a partial accumulation
        resync();
        set_all(0, 0);
        prod[0] = 7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cnt = out_cnt[1];
        prod[0] = 10;
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("clr count", out_cnt[1] - cnt, 1);
        chk("clr sum", last_d[1], 20);

        // stage 2 overflow, then a clean output clears the flag
        resync();
        set_all(0, 0);
        prod[0] = 32'h7fffffff;
        prod[6] = 1;
        in_valid = 1'b1;
        tick();
        set_all(0, 0);
        prod[0] = 3;
        tick();
        in_valid = 1'b0;
        tick();
`ifdef CONV_ADD_TREE_SAT_EN
        chk("ovf data", i1.out_data, 32'h7fffffff);
`else
        chk("ovf data", i1.out_data, 32'h80000000);
`endif
        chk("ovf flag", {31'b0, i1.out_ovf}, 1);
        tick();
        chk("ovf cleared data", i1.out_data, 3);
        chk("ovf cleared flag", {31'b0, i1.out_ovf}, 0);

        // randomized traffic with stalls, checked by the monitor against the model
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_IN; i++)
                prod[i] = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                                      : int'($urandom_range(0, 2000)) - 1000;
            bias = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
            tick();
        end
        en = 1'b1;
        in_valid = 1'b0;
        repeat (6) tick();

        // asynchronous reset in the middle of a CHANNELS=3 accumulation
        resync();
        set_all(1, 0);
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #3 rst_b = 1'b0;
        #1;
        chk("async rst data", i1.out_data, 0);
        chk("async rst ch3 data", i3.out_data, 0);
        model_reset();
        @(posedge clk);
        #1 rst_b = 1'b1;
        tick();
        cnt = out_cnt[2];
        for (int i = 0; i < N_IN; i++) prod[i] = i;
        bias = 9;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("post rst count", out_cnt[2] - cnt, 1);
        chk("post rst sum", last_d[2], 174);

        for (int c = 0; c < 3; c++)
            chk($sformatf("drain ch%0d", c+1), expq[c].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
